// File: rtl/game_pkg.sv
// Shared game-video types: pixel colour struct, layer indices and the
// frame-collision FSM state encoding.
package game_pkg;
  typedef struct packed {
    logic [7:0] r;
    logic [7:0] g;
    logic [7:0] b;
  } rgb_t;

  localparam int LAYER_PLAYER  = 0;
  localparam int LAYER_TERRAIN = 1;

  typedef enum logic {WAIT_FRAME, RUN} frame_state_t;
endpackage

// File: rtl/frame_collision_tracker.sv
// Per-frame player-vs-layer collision accumulator, reported on each v_sync rise.
// The partial frame seen after reset is discarded (WAIT_FRAME).
module frame_collision_tracker
  import game_pkg::*;
#(
  parameter int N_LAYERS = 4
) (
  input  logic                i_clk,
  input  logic                i_rst,
  input  logic                i_v_sync,
  input  logic [N_LAYERS-1:0] i_coll,
  output logic [N_LAYERS-1:0] o_collision_mask,
  output logic                o_collision_valid,
  output logic [15:0]         o_frame_cnt
);
  frame_state_t        state, state_nxt;
  logic                vs_prev;
  logic                rise;
  logic                report;
  logic [N_LAYERS-1:0] acc;

  assign rise = i_v_sync & ~vs_prev;

  always_ff @(posedge i_clk) begin
    if (i_rst) state <= WAIT_FRAME;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    if (state == WAIT_FRAME && rise) state_nxt = RUN;
  end

  always_comb begin
    report = (state == RUN) && rise;
  end

  // On a report edge the same-cycle collision term seeds the new frame.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      vs_prev           <= 1'b0;
      acc               <= '0;
      o_collision_mask  <= '0;
      o_collision_valid <= 1'b0;
      o_frame_cnt       <= '0;
    end else begin
      vs_prev           <= i_v_sync;
      o_collision_valid <= report;
      o_frame_cnt       <= o_frame_cnt + 16'(report);
      if (state == WAIT_FRAME) begin
        acc <= '0;
      end else if (report) begin
        o_collision_mask <= acc;
        acc              <= i_coll;
      end else begin
        acc <= acc | i_coll;
      end
    end
  end
endmodule

// File: rtl/sprite_layer_compositor.sv
// Two-stage priority mixer of N sprite layers over a flat background, plus
// per-frame player collision reporting.
module sprite_layer_compositor
  import game_pkg::*;
#(
  parameter int          N_LAYERS = 4,
  parameter logic [23:0] BG_RGB   = 24'h000000
) (
  input  logic                     i_clk,
  input  logic                     i_rst,
  input  logic                     i_de,
  input  logic                     i_v_sync,
  input  logic [N_LAYERS-1:0]      i_layer_hit,
  input  logic [24*N_LAYERS-1:0]   i_layer_rgb,
  output logic [7:0]               o_red,
  output logic [7:0]               o_green,
  output logic [7:0]               o_blue,
  output logic                     o_de,
  output logic [N_LAYERS-1:0]      o_collision_mask,
  output logic                     o_collision_valid,
  output logic [15:0]              o_frame_cnt
);
  logic                      s1_de;
  logic [N_LAYERS-1:0]       s1_hit;
  rgb_t [N_LAYERS-1:0]       s1_rgb;
  rgb_t                      mix;
  logic [N_LAYERS-1:0]       coll;

  // Non-hit colours are zeroed at capture so undriven data never propagates.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      s1_de  <= 1'b0;
      s1_hit <= '0;
      s1_rgb <= '0;
    end else begin
      s1_de  <= i_de;
      s1_hit <= i_layer_hit;
      for (int k = 0; k < N_LAYERS; k++)
        s1_rgb[k] <= i_layer_hit[k] ? rgb_t'(i_layer_rgb[24*k +: 24]) : '0;
    end
  end

  // Scan from lowest priority upward so the lowest hit index wins.
  always_comb begin
    mix = rgb_t'(BG_RGB);
    for (int k = N_LAYERS - 1; k >= 0; k--)
      if (s1_hit[k]) mix = s1_rgb[k];
  end

  always_comb begin
    coll = '0;
    for (int k = 1; k < N_LAYERS; k++)
      coll[k] = s1_de & s1_hit[LAYER_PLAYER] & s1_hit[k];
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      o_de                     <= 1'b0;
      {o_red, o_green, o_blue} <= '0;
    end else begin
      o_de                     <= s1_de;
      {o_red, o_green, o_blue} <= s1_de ? mix : '0;
    end
  end

  frame_collision_tracker #(.N_LAYERS(N_LAYERS)) u_trk (
    .i_clk             (i_clk),
    .i_rst             (i_rst),
    .i_v_sync          (i_v_sync),
    .i_coll            (coll),
    .o_collision_mask  (o_collision_mask),
    .o_collision_valid (o_collision_valid),
    .o_frame_cnt       (o_frame_cnt)
  );
endmodule

// File: tb/tb_sprite_layer_compositor.sv
// Scoreboard bench: stimulus pushes expected pixels/frame reports from a
// behavioural model; a monitor pops and compares after each clock edge.
module tb_sprite_layer_compositor;
  localparam logic [23:0] BG = 24'h102030;

  logic        clk = 1'b0;
  logic        rst = 1'b1, de = 1'b0, vs = 1'b0;
  logic [3:0]  hit = '0;
  logic [95:0] rgb = '0;
  logic [7:0]  red, green, blue;
  logic        ode, cvalid;
  logic [3:0]  cmask;
  logic [15:0] fcnt;

  always #5 clk = ~clk;

  sprite_layer_compositor #(.N_LAYERS(4), .BG_RGB(BG)) dut (
    .i_clk(clk), .i_rst(rst), .i_de(de), .i_v_sync(vs),
    .i_layer_hit(hit), .i_layer_rgb(rgb),
    .o_red(red), .o_green(green), .o_blue(blue), .o_de(ode),
    .o_collision_mask(cmask), .o_collision_valid(cvalid), .o_frame_cnt(fcnt)
  );

  int checks = 0, errors = 0;
  logic [24:0] pq[$];
  logic [19:0] rq[$];

  // previous cycle's stimulus, needed to place the 2-clock pixel result and
  // the stage-1 collision term
  logic        p_rst = 1'b1, p_de = 1'b0, p_vs = 1'b0;
  logic [3:0]  p_hit = '0;
  logic [95:0] p_rgb = '0;
  bit          p_vld = 0;

  bit          m_run = 0;
  logic [3:0]  m_acc = '0, m_mask = '0;
  logic [15:0] m_cnt = '0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  function automatic logic [24:0] ref_pix(input logic d, input logic [3:0] h, input logic [95:0] c);
    if (!d) return '0;
    for (int k = 0; k < 4; k++)
      if (h[k]) return {c[24*k +: 24], 1'b1};
    return {BG, 1'b1};
  endfunction

  task automatic step(input logic r, input logic d, input logic [3:0] h,
                      input logic [95:0] c, input logic v);
    logic       pv;
    logic [3:0] cl;
    @(negedge clk);
    rst = r; de = d; hit = h; rgb = c; vs = v;
    if (p_vld) pq.push_back((p_rst || r) ? 25'd0 : ref_pix(p_de, p_hit, p_rgb));
    if (r) begin
      m_run = 0; m_acc = '0; m_mask = '0; m_cnt = '0;
    end else begin
      pv = p_rst ? 1'b0 : p_vs;
      cl = (!p_rst && p_de && p_hit[0]) ? (p_hit & 4'b1110) : 4'b0000;
      if (v && !pv) begin
        if (m_run) begin
          m_mask = m_acc;
          m_cnt  = m_cnt + 16'd1;
          rq.push_back({m_mask, m_cnt});
          m_acc  = cl;
        end else begin
          m_run = 1;
        end
      end else if (m_run) begin
        m_acc = m_acc | cl;
      end
    end
    p_rst = r; p_de = d; p_hit = h; p_rgb = c; p_vs = v; p_vld = 1;
  endtask

  task automatic idle(input logic v);
    step(1'b0, 1'b0, 4'b0000, {$urandom, $urandom, $urandom}, v);
  endtask

  always @(posedge clk) begin
    logic [24:0] e;
    logic [19:0] rp;
    #1;
    if (pq.size() > 0) begin
      e = pq.pop_front();
      chk("pixel", {7'd0, red, green, blue, ode}, {7'd0, e});
      chk("pixel_known", 32'($isunknown({red, green, blue, ode})), 32'd0);
    end
    if (cvalid) begin
      if (rq.size() == 0) chk("spurious_valid", 32'd1, 32'd0);
      else begin
        rp = rq.pop_front();
        chk("report", {12'd0, cmask, fcnt}, {12'd0, rp});
      end
    end else if (rq.size() > 0) begin
      rp = rq.pop_front();
      chk("missed_valid", 32'd0, 32'd1);
    end
    chk("mask_state", {28'd0, cmask}, {28'd0, m_mask});
    chk("frame_cnt",  {16'd0, fcnt},  {16'd0, m_cnt});
  end

  initial begin
    logic [95:0] c;
    logic        vr;
    // reset with random inputs, then background pixel
    repeat (3) step(1'b1, 1'($urandom), 4'($urandom), {$urandom, $urandom, $urandom}, 1'($urandom));
    step(1'b0, 1'b1, 4'b0000, {$urandom, $urandom, $urandom}, 1'b0);
    // priority / latency
    c = {24'h0F0F0F, 24'hFF0000, 24'hA0A0A0, 24'h0000FF};
    step(1'b0, 1'b1, 4'b0110, c, 1'b0);
    step(1'b0, 1'b1, 4'b0000, c, 1'b0);
    step(1'b0, 1'b0, 4'b1111, c, 1'b0);
    step(1'b0, 1'b1, 4'b1000, c, 1'b0);
    step(1'b0, 1'b1, 4'b0001, c, 1'b0);
    // undriven colour on a non-hit layer
    step(1'b0, 1'b1, 4'b0010, {24'hxxxxxx, 24'hxxxxxx, 24'h123456, 24'hxxxxxx}, 1'b0);
    idle(1'b0);
    // collision frames
    step(1'b1, 1'b0, 4'b0000, c, 1'b0);
    idle(1'b0);
    idle(1'b1); idle(1'b1); idle(1'b0);
    step(1'b0, 1'b1, 4'b0011, c, 1'b0);
    idle(1'b0);
    idle(1'b1); idle(1'b0);
    step(1'b0, 1'b1, 4'b0110, c, 1'b0);
    idle(1'b1); idle(1'b0);
    // overlap coincident with the edge
    step(1'b0, 1'b1, 4'b0011, c, 1'b0);
    step(1'b0, 1'b1, 4'b1001, c, 1'b0);
    idle(1'b1); idle(1'b0); idle(1'b0);
    idle(1'b1); idle(1'b0);
    // mid-frame reset
    step(1'b0, 1'b1, 4'b0101, c, 1'b0);
    step(1'b1, 1'b0, 4'b0000, c, 1'b0);
    idle(1'b0);
    idle(1'b1); idle(1'b0);
    step(1'b0, 1'b1, 4'b0011, c, 1'b0);
    idle(1'b0);
    // counter wrap
    force dut.u_trk.o_frame_cnt = 16'hFFFF;
    m_cnt = 16'hFFFF;
    @(posedge clk); #2;
    release dut.u_trk.o_frame_cnt;
    idle(1'b0);
    idle(1'b1); idle(1'b0);
    // random traffic
    vr = 1'b0;
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 24) == 0) vr = ~vr;
      step(($urandom_range(0, 299) == 0), 1'($urandom), 4'($urandom),
           {$urandom, $urandom, $urandom}, vr);
    end
    repeat (4) idle(1'b0);
    @(posedge clk); #2;
    chk("drained", 32'(rq.size() + pq.size()), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
